execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 Parameter NREG, default 8: number of architectural registers; register IDs 0..NREG-1 are valid, 4'hF means "no register".
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  decode presents a valid instruction.
REQ-006 in_ready  output  1  stage accepts; transfer occurs when in_valid && in_ready at a rising edge.
REQ-007 in_icode, in_ifun, in_rA, in_rB  input  4 each  decoded fields (instruction bits [31:28], [27:24], [23:20], [19:16]).
REQ-008 in_valC  input  16  immediate (instruction bits [15:0]).
REQ-009 in_valA, in_valB  input  XLEN each  regfile read data for in_rA and in_rB.
REQ-010 w_valid  output  1  writeback port carries a write this cycle.
REQ-011 w_dst  output  4  destination register ID (4'hF when w_valid=0).
REQ-012 w_val  output  XLEN  write data.
REQ-013 cc  output  3  condition codes {ZF,SF,OF}.
REQ-014 halted, error  output  1 each  status flags.

Function
REQ-015 Opcodes ({icode,ifun}): 8'h00 NOP; 8'h01 HALT; 8'h10 IRMOV (rB <- zero-extended valC); 8'h20 ADD, 8'h21 SUB (rA-rB), 8'h22 AND, 8'h23 XOR (rA <- rA op rB).
REQ-016 An accepted instruction is latched into register E at edge N; its result appears on w_valid/w_dst/w_val during cycle N+1 (register W); the regfile commits it at edge N+2.
REQ-017 Arithmetic is modulo 2^XLEN; OF = signed overflow for ADD/SUB and 0 for AND/XOR; ZF = (result==0); SF = result[XLEN-1].
REQ-018 cc updates only when an ALU op (8'h20-8'h23) enters W; IRMOV, NOP and HALT leave cc unchanged.
REQ-019 Forwarding: an operand whose ID equals the E-stage destination takes the E result; otherwise, if it equals the W-stage destination with w_valid=1, it takes w_val; otherwise it takes in_valA/in_valB. E has priority over W.
REQ-020 The stage never stalls on data hazards; back-to-back dependent instructions produce architecturally correct results.
REQ-021 FSM states: RUN, HALTED, ERROR. In RUN, in_ready=1.
REQ-022 HALT accepted in RUN: transition to HALTED at that edge; in_ready=0; instructions already in E and W complete their writeback.
REQ-023 An unknown opcode, or a used register ID in the range NREG..14, causes a transition to ERROR: the instruction produces no write, in_ready=0, error=1, and in-flight instructions drain.
REQ-024 HALTED and ERROR are sticky until reset.
REQ-025 NOP and HALT never assert w_valid.
REQ-026 When in_valid=0 in RUN, a bubble (no write) enters E.

Reset
REQ-027 reset=1 at an edge: state RUN, E and W hold bubbles, w_valid=0, w_dst=4'hF, w_val=0, cc=3'b000, halted=0, error=0.
REQ-028 Reset asserted mid-operation discards all in-flight instructions; no write occurs in the cycle following the reset edge.
REQ-029 After reset, in_ready=1 in the first cycle.

Structure
REQ-030 Opcode constants (NOP, HALT, IRMOV, ADD, SUB, AND, XOR), the RNONE constant (4'hF) and the FSM state encoding live in a shared package used by decode and execute.
REQ-031 The ALU (result and flags from aluA, aluB, alufun) is a separate sub-module named alu.

Verification
REQ-032 IRMOV 8'h10, rB=3, valC=16'h0083 accepted at edge N -> w_valid=1, w_dst=3, w_val=32'h00000083 during cycle N+1.
REQ-033 Back-to-back: IRMOV r0=0x80, IRMOV r1=0x81, then ADD r0,r1, with stale in_valA/in_valB=0 -> w_dst=0, w_val=0x101 (forwarding from E and W), cc=000.
REQ-034 SUB r2,r3 with r2=r3=0x5 -> w_val=0, cc ZF=1; ADD 0x7FFFFFFF+1 -> w_val=0x80000000, SF=1, OF=1.
REQ-035 IRMOV, IRMOV, HALT, ADD presented back-to-back -> both IRMOVs write back, halted=1, in_ready=0, ADD never accepted, no further writes.
REQ-036 Opcode 8'h35 -> error=1, no write for it, the preceding IRMOV still writes; reset pulse -> all flags clear, in_ready=1.
REQ-037 Reset asserted while E and W are occupied -> w_valid=0 in the following cycle and cc=000.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// ============================================================================
// Module      : execute_stage_pkg
// Description : Opcodes, register-ID sentinel, FSM states and decode helpers
//               shared by decode and the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package execute_stage_pkg;

    localparam logic [3:0] c_RNONE     = 4'hF;

    localparam logic [7:0] c_OP_NOP    = 8'h00;
    localparam logic [7:0] c_OP_HALT   = 8'h01;
    localparam logic [7:0] c_OP_IRMOV  = 8'h10;
    localparam logic [7:0] c_OP_ADD    = 8'h20;
    localparam logic [7:0] c_OP_SUB    = 8'h21;
    localparam logic [7:0] c_OP_AND    = 8'h22;
    localparam logic [7:0] c_OP_XOR    = 8'h23;

    // ALU function codes equal ifun[1:0] of the ALU opcodes
    localparam logic [1:0] c_ALU_ADD   = 2'd0;
    localparam logic [1:0] c_ALU_SUB   = 2'd1;
    localparam logic [1:0] c_ALU_AND   = 2'd2;
    localparam logic [1:0] c_ALU_XOR   = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_ERROR  = 2'd2
    } state_e;

    function automatic logic reg_out_of_range(input logic [3:0] id, input int nreg);
        return (id != c_RNONE) && (int'(id) >= nreg);
    endfunction

endpackage

`default_nettype wire

// File: rtl/execute_stage_alu.sv
// ============================================================================
// Module      : alu
// Description : Combinational ALU producing result and {ZF,SF,OF}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import execute_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] alu_a_i,
    input  logic [XLEN-1:0] alu_b_i,
    input  logic [1:0]      alufun_i,
    output logic [XLEN-1:0] result_o,
    output logic [2:0]      flags_o
);

    logic w_ovf;

    always_comb begin
        result_o = '0;
        w_ovf    = 1'b0;
        case (alufun_i)
            c_ALU_ADD: begin
                result_o = alu_a_i + alu_b_i;
                w_ovf    = (alu_a_i[XLEN-1] == alu_b_i[XLEN-1]) &&
                           (result_o[XLEN-1] != alu_a_i[XLEN-1]);
            end
            c_ALU_SUB: begin
                result_o = alu_a_i - alu_b_i;
                w_ovf    = (alu_a_i[XLEN-1] != alu_b_i[XLEN-1]) &&
                           (result_o[XLEN-1] != alu_a_i[XLEN-1]);
            end
            c_ALU_AND: result_o = alu_a_i & alu_b_i;
            default:   result_o = alu_a_i ^ alu_b_i;
        endcase
        flags_o = {(result_o == '0), result_o[XLEN-1], w_ovf};
    end

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
// Module      : execute_stage
// Description : Two-register (E, W) execute stage with full forwarding,
//               condition codes and a RUN/HALTED/ERROR status FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_icode,
    input  logic [3:0]      in_ifun,
    input  logic [3:0]      in_rA,
    input  logic [3:0]      in_rB,
    input  logic [15:0]     in_valC,
    input  logic [XLEN-1:0] in_valA,
    input  logic [XLEN-1:0] in_valB,
    output logic            w_valid,
    output logic [3:0]      w_dst,
    output logic [XLEN-1:0] w_val,
    output logic [2:0]      cc,
    output logic            halted,
    output logic            error
);

    state_e          state_q;
    logic            in_ready_q, halted_q, error_q;

    logic            e_wr_q, e_alu_q;
    logic [1:0]      e_fun_q;
    logic [3:0]      e_dst_q;
    logic [XLEN-1:0] e_a_q, e_b_q;

    logic            w_valid_q;
    logic [3:0]      w_dst_q;
    logic [XLEN-1:0] w_val_q;
    logic [2:0]      cc_q;

    logic            e_wr_d, e_alu_d;
    logic [3:0]      e_dst_d;
    logic [XLEN-1:0] e_a_d, e_b_d;

    logic [7:0]      op;
    logic            dec_halt, dec_bad, dec_wr, dec_alu, accept, take;
    logic [3:0]      dec_dst;
    logic [XLEN-1:0] fwd_a, fwd_b, valc_ext, alu_res, e_res;
    logic [2:0]      alu_flags;

    assign op       = {in_icode, in_ifun};
    assign valc_ext = {{(XLEN-16){1'b0}}, in_valC};
    assign accept   = in_valid && in_ready_q;
    assign take     = accept && !dec_halt && !dec_bad;

    always_comb begin
        dec_halt = 1'b0;
        dec_bad  = 1'b0;
        dec_wr   = 1'b0;
        dec_alu  = 1'b0;
        dec_dst  = c_RNONE;
        case (op)
            c_OP_NOP:  ;
            c_OP_HALT: dec_halt = 1'b1;
            c_OP_IRMOV: begin
                dec_bad = reg_out_of_range(in_rB, NREG);
                dec_wr  = (in_rB != c_RNONE);
                dec_dst = in_rB;
            end
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_XOR: begin
                dec_bad = reg_out_of_range(in_rA, NREG) || reg_out_of_range(in_rB, NREG);
                dec_alu = 1'b1;
                dec_wr  = (in_rA != c_RNONE);
                dec_dst = in_rA;
            end
            default:   dec_bad = 1'b1;
        endcase
    end

    // The youngest in-flight producer (E) wins over the older one (W)
    always_comb begin
        fwd_a = in_valA;
        if (in_rA != c_RNONE && e_wr_q && in_rA == e_dst_q)
            fwd_a = e_res;
        else if (in_rA != c_RNONE && w_valid_q && in_rA == w_dst_q)
            fwd_a = w_val_q;

        fwd_b = in_valB;
        if (in_rB != c_RNONE && e_wr_q && in_rB == e_dst_q)
            fwd_b = e_res;
        else if (in_rB != c_RNONE && w_valid_q && in_rB == w_dst_q)
            fwd_b = w_val_q;
    end

    always_comb begin
        e_wr_d  = take && dec_wr;
        e_alu_d = take && dec_alu;
        e_dst_d = (take && dec_wr) ? dec_dst : c_RNONE;
        e_a_d   = fwd_a;
        e_b_d   = dec_alu ? fwd_b : valc_ext;
    end

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .alu_a_i  (e_a_q),
        .alu_b_i  (e_b_q),
        .alufun_i (e_fun_q),
        .result_o (alu_res),
        .flags_o  (alu_flags)
    );

    // Non-ALU entries carry their write value (IRMOV immediate) in e_b_q
    assign e_res = e_alu_q ? alu_res : e_b_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            in_ready_q <= 1'b1;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
        end else if (state_q == ST_RUN && accept) begin
            if (dec_bad) begin
                state_q    <= ST_ERROR;
                in_ready_q <= 1'b0;
                error_q    <= 1'b1;
            end else if (dec_halt) begin
                state_q    <= ST_HALTED;
                in_ready_q <= 1'b0;
                halted_q   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            e_wr_q    <= 1'b0;
            e_alu_q   <= 1'b0;
            e_fun_q   <= 2'd0;
            e_dst_q   <= c_RNONE;
            e_a_q     <= '0;
            e_b_q     <= '0;
            w_valid_q <= 1'b0;
            w_dst_q   <= c_RNONE;
            w_val_q   <= '0;
            cc_q      <= 3'b000;
        end else begin
            e_wr_q    <= e_wr_d;
            e_alu_q   <= e_alu_d;
            e_fun_q   <= in_ifun[1:0];
            e_dst_q   <= e_dst_d;
            e_a_q     <= e_a_d;
            e_b_q     <= e_b_d;
            w_valid_q <= e_wr_q;
            w_dst_q   <= e_wr_q ? e_dst_q : c_RNONE;
            w_val_q   <= e_wr_q ? e_res : '0;
            if (e_alu_q)
                cc_q <= alu_flags;
        end
    end

    assign in_ready = in_ready_q;
    assign halted   = halted_q;
    assign error    = error_q;
    assign w_valid  = w_valid_q;
    assign w_dst    = w_dst_q;
    assign w_val    = w_val_q;
    assign cc       = cc_q;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// Module      : tb_execute_stage
// Description : Directed and randomized checks of execute_stage against an
//               in-order architectural model with a bench-side register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_execute_stage;

    localparam int XLEN = 32;
    localparam int NREG = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      in_icode = 4'h0, in_ifun = 4'h0, in_rA = 4'hF, in_rB = 4'hF;
    logic [15:0]     in_valC = 16'h0;
    logic [XLEN-1:0] in_valA = '0, in_valB = '0;
    logic            w_valid;
    logic [3:0]      w_dst;
    logic [XLEN-1:0] w_val;
    logic [2:0]      cc;
    logic            halted, error;

    always #5 clock = ~clock;

    execute_stage #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
        .in_valC(in_valC), .in_valA(in_valA), .in_valB(in_valB),
        .w_valid(w_valid), .w_dst(w_dst), .w_val(w_val), .cc(cc),
        .halted(halted), .error(error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // rf: register file committed from the writeback port; arch: program-order state
    logic [XLEN-1:0] rf   [16];
    logic [XLEN-1:0] arch [16];

    typedef struct packed {
        logic            v;
        logic [3:0]      dst;
        logic [XLEN-1:0] val;
        logic [2:0]      cc;
    } exp_t;

    exp_t     expq[$];
    int       mstate;      // 0 run, 1 halted, 2 error
    logic [2:0] ccm;

    initial begin
        for (int i = 0; i < 16; i++) begin
            rf[i]   = '0;
            arch[i] = '0;
        end
    end

    // Reference: every instruction executes atomically in program order; its
    // observable write shows up one edge after the edge it was accepted on.
    always @(posedge clock) begin
        exp_t            e;
        logic [7:0]      op;
        logic [XLEN-1:0] a, b, r;
        longint          sa, sb, s;
        if (reset) begin
            for (int i = 0; i < 16; i++) arch[i] = rf[i];
            mstate = 0;
            ccm    = 3'b000;
            e      = '{v: 1'b0, dst: 4'hF, val: '0, cc: 3'b000};
            expq.delete();
            expq.push_back(e);
            expq.push_back(e);
        end else begin
            if (w_valid) rf[w_dst] <= w_val;
            e = '{v: 1'b0, dst: 4'hF, val: '0, cc: ccm};
            if (mstate == 0 && in_valid) begin
                op = {in_icode, in_ifun};
                if (op == 8'h01) begin
                    mstate = 1;
                end else if (op == 8'h10) begin
                    if (in_rB >= NREG) mstate = 2;
                    else begin
                        r = XLEN'(in_valC);
                        arch[in_rB] = r;
                        e = '{v: 1'b1, dst: in_rB, val: r, cc: ccm};
                    end
                end else if (op >= 8'h20 && op <= 8'h23) begin
                    if (in_rA >= NREG || in_rB >= NREG) mstate = 2;
                    else begin
                        a  = arch[in_rA];
                        b  = arch[in_rB];
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                        case (op)
                            8'h20:   begin r = a + b; s = sa + sb; end
                            8'h21:   begin r = a - b; s = sa - sb; end
                            8'h22:   begin r = a & b; s = longint'($signed(r)); end
                            default: begin r = a ^ b; s = longint'($signed(r)); end
                        endcase
                        ccm = {(r == '0), r[XLEN-1], (s != longint'($signed(r)))};
                        arch[in_rA] = r;
                        e = '{v: 1'b1, dst: in_rA, val: r, cc: ccm};
                    end
                end else if (op != 8'h00) begin
                    mstate = 2;
                end
            end
            expq.push_back(e);
            void'(expq.pop_front());
        end
    end

    task automatic drive(input logic v, input logic [7:0] op, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [15:0] c);
        in_valid = v;
        {in_icode, in_ifun} = op;
        in_rA   = ra;
        in_rB   = rb;
        in_valC = c;
        in_valA = rf[ra];
        in_valB = rf[rb];
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        drive(1'b0, 8'h00, 4'hF, 4'hF, 16'h0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset_pulse();
        n_checks++; if (w_valid !== 1'b0) $display("FAIL reset_wvalid got %b want 0", w_valid); else n_pass++;
        n_checks++; if (w_dst !== 4'hF) $display("FAIL reset_wdst got %h want f", w_dst); else n_pass++;
        n_checks++; if (w_val !== 32'h0) $display("FAIL reset_wval got %h want 0", w_val); else n_pass++;
        n_checks++; if (cc !== 3'b000) $display("FAIL reset_cc got %b want 000", cc); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL reset_error got %b want 0", error); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_inready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_irmov();
        drive(1'b1, 8'h10, 4'hF, 4'h3, 16'h0083);
        step();
        n_checks++; if (w_valid !== 1'b0) $display("FAIL irmov_latency got w_valid=%b want 0", w_valid); else n_pass++;
        drive(1'b0, 8'h00, 4'hF, 4'hF, 16'h0);
        step();
        n_checks++; if (w_valid !== 1'b1) $display("FAIL irmov_wvalid got %b want 1", w_valid); else n_pass++;
        n_checks++; if (w_dst !== 4'h3) $display("FAIL irmov_wdst got %h want 3", w_dst); else n_pass++;
        n_checks++; if (w_val !== 32'h83) $display("FAIL irmov_wval got %h want 00000083", w_val); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 8'h10, 4'hF, 4'h0, 16'h0080); step();
        drive(1'b1, 8'h10, 4'hF, 4'h1, 16'h0081); step();
        drive(1'b1, 8'h20, 4'h0, 4'h1, 16'h0);
        in_valA = '0;
        in_valB = '0;
        step();
        drive(1'b0, 8'h00, 4'hF, 4'hF, 16'h0); step();
        n_checks++; if (w_valid !== 1'b1) $display("FAIL b2b_wvalid got %b want 1", w_valid); else n_pass++;
        n_checks++; if (w_dst !== 4'h0) $display("FAIL b2b_wdst got %h want 0", w_dst); else n_pass++;
        n_checks++; if (w_val !== 32'h101) $display("FAIL b2b_wval got %h want 00000101", w_val); else n_pass++;
        n_checks++; if (cc !== 3'b000) $display("FAIL b2b_cc got %b want 000", cc); else n_pass++;
        step(); step();
    endtask

    task automatic test_flags();
        drive(1'b1, 8'h10, 4'hF, 4'h2, 16'h0005); step();
        drive(1'b1, 8'h10, 4'hF, 4'h3, 16'h0005); step();
        drive(1'b1, 8'h21, 4'h2, 4'h3, 16'h0);    step();
        drive(1'b0, 8'h00, 4'hF, 4'hF, 16'h0);    step();
        n_checks++; if (w_val !== 32'h0) $display("FAIL sub_wval got %h want 0", w_val); else n_pass++;
        n_checks++; if (cc !== 3'b100) $display("FAIL sub_cc got %b want 100", cc); else n_pass++;
        step(); step();
        drive(1'b1, 8'h20, 4'h5, 4'h6, 16'h0);
        in_valA = 32'h7FFF_FFFF;
        in_valB = 32'h0000_0001;
        step();
        drive(1'b0, 8'h00, 4'hF, 4'hF, 16'h0); step();
        n_checks++; if (w_val !== 32'h8000_0000) $display("FAIL ovf_wval got %h want 80000000", w_val); else n_pass++;
        n_checks++; if (cc !== 3'b011) $display("FAIL ovf_cc got %b want 011", cc); else n_pass++;
        step(); step();
    endtask

    task automatic test_halt();
        reset_pulse();
        drive(1'b1, 8'h10, 4'hF, 4'h1, 16'h0011); step();
        drive(1'b1, 8'h10, 4'hF, 4'h2, 16'h0022); step();
        n_checks++; if (w_valid !== 1'b1 || w_dst !== 4'h1 || w_val !== 32'h11)
            $display("FAIL halt_first_write got v=%b d=%h val=%h want 1/1/11", w_valid, w_dst, w_val); else n_pass++;
        drive(1'b1, 8'h01, 4'hF, 4'hF, 16'h0); step();
        n_checks++; if (w_valid !== 1'b1 || w_dst !== 4'h2 || w_val !== 32'h22)
            $display("FAIL halt_second_write got v=%b d=%h val=%h want 1/2/22", w_valid, w_dst, w_val); else n_pass++;
        n_checks++; if (halted !== 1'b1) $display("FAIL halt_flag got %b want 1", halted); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL halt_inready got %b want 0", in_ready); else n_pass++;
        drive(1'b1, 8'h20, 4'h1, 4'h2, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (w_valid !== 1'b0) $display("FAIL halt_nowrite cycle %0d got %b want 0", i, w_valid); else n_pass++;
        end
        n_checks++; if (halted !== 1'b1 || error !== 1'b0) $display("FAIL halt_sticky got h=%b e=%b want 1/0", halted, error); else n_pass++;
    endtask

    task automatic test_error();
        reset_pulse();
        drive(1'b1, 8'h10, 4'hF, 4'h4, 16'h0044); step();
        drive(1'b1, 8'h35, 4'h1, 4'h2, 16'h0);    step();
        n_checks++; if (error !== 1'b1) $display("FAIL err_flag got %b want 1", error); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL err_inready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (w_valid !== 1'b1 || w_dst !== 4'h4 || w_val !== 32'h44)
            $display("FAIL err_prev_write got v=%b d=%h val=%h want 1/4/44", w_valid, w_dst, w_val); else n_pass++;
        drive(1'b1, 8'h10, 4'hF, 4'h5, 16'h0055);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (w_valid !== 1'b0) $display("FAIL err_nowrite cycle %0d got %b want 0", i, w_valid); else n_pass++;
        end
        reset_pulse();
        n_checks++; if (error !== 1'b0 || halted !== 1'b0) $display("FAIL err_clear got e=%b h=%b want 0/0", error, halted); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL err_clear_inready got %b want 1", in_ready); else n_pass++;
        // Register ID 9 is out of range for NREG=8
        drive(1'b1, 8'h20, 4'h9, 4'h1, 16'h0); step();
        n_checks++; if (error !== 1'b1) $display("FAIL badreg_flag got %b want 1", error); else n_pass++;
        drive(1'b0, 8'h00, 4'hF, 4'hF, 16'h0); step();
        n_checks++; if (w_valid !== 1'b0) $display("FAIL badreg_nowrite got %b want 0", w_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        reset_pulse();
        drive(1'b1, 8'h21, 4'h1, 4'h2, 16'h0);
        in_valA = 32'h3;
        in_valB = 32'h3;
        step();
        drive(1'b0, 8'h00, 4'hF, 4'hF, 16'h0); step();
        n_checks++; if (cc !== 3'b100) $display("FAIL rmid_cc_pre got %b want 100", cc); else n_pass++;
        drive(1'b1, 8'h10, 4'hF, 4'h1, 16'h0007); step();
        drive(1'b1, 8'h10, 4'hF, 4'h2, 16'h0009); step();
        reset = 1'b1;
        drive(1'b1, 8'h10, 4'hF, 4'h3, 16'h000A); step();
        n_checks++; if (w_valid !== 1'b0) $display("FAIL rmid_wvalid got %b want 0", w_valid); else n_pass++;
        n_checks++; if (w_dst !== 4'hF) $display("FAIL rmid_wdst got %h want f", w_dst); else n_pass++;
        n_checks++; if (cc !== 3'b000) $display("FAIL rmid_cc got %b want 000", cc); else n_pass++;
        reset = 1'b0;
        drive(1'b0, 8'h00, 4'hF, 4'hF, 16'h0); step();
        n_checks++; if (w_valid !== 1'b0) $display("FAIL rmid_drain got %b want 0", w_valid); else n_pass++;
    endtask

    task automatic test_random();
        int         k;
        logic [7:0] op;
        logic       v;
        reset_pulse();
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            if (k < 5)      op = {6'b001000, 2'($urandom_range(0, 3))};
            else if (k < 9) op = 8'h10;
            else            op = 8'h00;
            v = ($urandom_range(0, 4) != 0);
            drive(v, op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 16'($urandom));
            step();
            n_checks++; if (w_valid !== expq[0].v)
                $display("FAIL rand_wvalid cyc %0d got %b want %b", i, w_valid, expq[0].v); else n_pass++;
            n_checks++; if (w_dst !== expq[0].dst)
                $display("FAIL rand_wdst cyc %0d got %h want %h", i, w_dst, expq[0].dst); else n_pass++;
            if (expq[0].v) begin
                n_checks++; if (w_val !== expq[0].val)
                    $display("FAIL rand_wval cyc %0d got %h want %h", i, w_val, expq[0].val); else n_pass++;
            end
            n_checks++; if (cc !== expq[0].cc)
                $display("FAIL rand_cc cyc %0d got %b want %b", i, cc, expq[0].cc); else n_pass++;
            n_checks++; if (in_ready !== (mstate == 0))
                $display("FAIL rand_inready cyc %0d got %b want %b", i, in_ready, (mstate == 0)); else n_pass++;
        end
        drive(1'b0, 8'h00, 4'hF, 4'hF, 16'h0);
        step(); step(); step();
        for (int r = 0; r < NREG; r++) begin
            n_checks++; if (rf[r] !== arch[r])
                $display("FAIL rand_regfile r%0d got %h want %h", r, rf[r], arch[r]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_irmov();
        test_back_to_back();
        test_flags();
        test_halt();
        test_error();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
